// File: rtl/anton_neopixel_apb_multi.sv
// Multi-channel WS2812 controller: APB3 slave with per-channel byte banks,
// control/status registers and a lock-step serializer driving CHANNELS strips.
module anton_neopixel_apb_multi #(
  parameter int CHANNELS     = 4,
  parameter int BANK_BITS    = 6,
  parameter int RESET_CYCLES = 400
) (
  input  logic                clk7mhz,
  input  logic                reset,
  input  logic                apbPselx,
  input  logic                apbPenable,
  input  logic                apbPwrite,
  input  logic [15:0]         apbPaddr,
  input  logic [7:0]          apbPwData,
  output logic [7:0]          apbPrData,
  output logic                apbPready,
  output logic                apbPslverr,
  output logic [CHANNELS-1:0] neoData,
  output logic                neoState,
  output logic                irq
);

  localparam int CH_W       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int BANK_DEPTH = 2 ** BANK_BITS;
  localparam int LAT_W      = $clog2(RESET_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, BIT, LATCH} SerState;

  SerState state, stateNext;

  logic [7:0] mem [2 ** CH_W][BANK_DEPTH];
  logic [7:0] byteReg [CHANNELS];

  logic [12:0]          idx, chanFull;
  logic [CH_W-1:0]      chanSel;
  logic [BANK_BITS-1:0] byteSel;
  logic [1:0]           regSel;
  logic                 isReg, bufErr, regErr, accessErr;
  logic                 setupRead, writeCommit, bufWrite, regWrite;
  logic [7:0]           rdValue;
  logic [1:0]           unusedAddr;

  logic                 run, loopMode, irqEnable, done;
  logic [BANK_BITS-1:0] lengthReg, len, bytePtr, nextPtr;
  logic [3:0]           phase;
  logic [2:0]           bitIdx;
  logic [LAT_W-1:0]     latchCnt;
  logic                 startFrame, nextByte, finishFrame;

  assign idx        = apbPaddr[14:2];
  assign chanFull   = idx >> BANK_BITS;
  assign chanSel    = idx[BANK_BITS +: CH_W];
  assign byteSel    = idx[BANK_BITS-1:0];
  assign regSel     = apbPaddr[3:2];
  assign isReg      = apbPaddr[15];
  assign unusedAddr = apbPaddr[1:0];
  assign bufErr     = !isReg && (chanFull >= 13'(CHANNELS));
  assign regErr     = isReg && (apbPaddr[14:4] != '0);
  assign accessErr  = bufErr || regErr;

  assign setupRead   = apbPselx && !apbPenable && !apbPwrite;
  assign writeCommit = apbPselx && apbPenable && apbPwrite && !accessErr;
  assign bufWrite    = writeCommit && !isReg;
  assign regWrite    = writeCommit && isReg;

  assign apbPready  = 1'b1;
  assign apbPslverr = apbPselx && apbPenable && accessErr;
  assign neoState   = (state != IDLE);
  assign irq        = done && irqEnable;
  assign nextPtr    = bytePtr + BANK_BITS'(1);

  always_comb begin
    rdValue = '0;
    if (!accessErr) begin
      if (isReg) begin
        case (regSel)
          2'd0:    rdValue = {5'd0, irqEnable, loopMode, run};
          2'd1:    rdValue = {6'd0, done, neoState};
          2'd2:    rdValue = 8'(lengthReg);
          default: rdValue = 8'(CHANNELS);
        endcase
      end else begin
        rdValue = mem[chanSel][byteSel];
      end
    end
  end

  // Pixel banks are deliberately left unreset so frame data survives a soft reset.
  always_ff @(posedge clk7mhz) begin
    if (bufWrite) mem[chanSel][byteSel] <= apbPwData;
  end

  // A frame-done set beats a simultaneous W1C; a CTRL write beats the end-of-frame run clear.
  always_ff @(posedge clk7mhz) begin
    if (reset) begin
      run       <= 1'b0;
      loopMode  <= 1'b0;
      irqEnable <= 1'b0;
      done      <= 1'b0;
      lengthReg <= '1;
      apbPrData <= '0;
    end else begin
      if (setupRead) apbPrData <= rdValue;
      if (finishFrame) run <= 1'b0;
      if (regWrite) begin
        case (regSel)
          2'd0:    {irqEnable, loopMode, run} <= apbPwData[2:0];
          2'd2:    lengthReg <= apbPwData[BANK_BITS-1:0];
          default: ;
        endcase
      end
      if (finishFrame) done <= 1'b1;
      else if (regWrite && regSel == 2'd1 && apbPwData[1]) done <= 1'b0;
    end
  end

  always_ff @(posedge clk7mhz) begin
    if (reset) state <= IDLE;
    else       state <= stateNext;
  end

  always_comb begin
    stateNext   = state;
    startFrame  = 1'b0;
    nextByte    = 1'b0;
    finishFrame = 1'b0;
    case (state)
      IDLE: begin
        if (run) begin
          stateNext  = BIT;
          startFrame = 1'b1;
        end
      end
      BIT: begin
        if (phase == 4'd8 && bitIdx == 3'd0) begin
          if (bytePtr == len) stateNext = LATCH;
          else                nextByte  = 1'b1;
        end
      end
      LATCH: begin
        if (latchCnt == LAT_W'(RESET_CYCLES - 1)) begin
          if (run && loopMode) begin
            stateNext  = BIT;
            startFrame = 1'b1;
          end else begin
            stateNext   = IDLE;
            finishFrame = 1'b1;
          end
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  // Each bit is 9 clocks; the high time is 6 for a one and 3 for a zero.
  always_ff @(posedge clk7mhz) begin
    if (reset) begin
      phase    <= '0;
      bitIdx   <= 3'd7;
      bytePtr  <= '0;
      len      <= '0;
      latchCnt <= '0;
      neoData  <= '0;
      for (int c = 0; c < CHANNELS; c++) byteReg[c] <= '0;
    end else begin
      if (startFrame) begin
        len     <= lengthReg;
        bytePtr <= '0;
        bitIdx  <= 3'd7;
        phase   <= '0;
        for (int c = 0; c < CHANNELS; c++) byteReg[c] <= mem[c][BANK_BITS'(0)];
      end else if (state == BIT) begin
        phase <= (phase == 4'd8) ? 4'd0 : phase + 4'd1;
        if (phase == 4'd8) bitIdx <= bitIdx - 3'd1;
        if (nextByte) begin
          bytePtr <= nextPtr;
          for (int c = 0; c < CHANNELS; c++) byteReg[c] <= mem[c][nextPtr];
        end
      end
      latchCnt <= (state == LATCH) ? latchCnt + LAT_W'(1) : '0;
      for (int c = 0; c < CHANNELS; c++)
        neoData[c] <= (state == BIT) && (phase < (byteReg[c][bitIdx] ? 4'd6 : 4'd3));
    end
  end

endmodule

// File: tb/tb_anton_neopixel_apb_multi.sv
// Directed-plus-random bench for anton_neopixel_apb_multi; waveforms are
// checked cycle by cycle against an arithmetic model of the WS2812 bit timing.
module tb_anton_neopixel_apb_multi;

  localparam int CH = 4;
  localparam int BB = 6;
  localparam int RC = 400;

  logic          clk7mhz    = 1'b0;
  logic          reset      = 1'b1;
  logic          apbPselx   = 1'b0;
  logic          apbPenable = 1'b0;
  logic          apbPwrite  = 1'b0;
  logic [15:0]   apbPaddr   = '0;
  logic [7:0]    apbPwData  = '0;
  logic [7:0]    apbPrData;
  logic          apbPready;
  logic          apbPslverr;
  logic [CH-1:0] neoData;
  logic          neoState;
  logic          irq;

  int checks = 0;
  int errors = 0;

  logic [7:0]  modelMem [CH][2 ** BB];
  int          schedAt   = -1;
  logic [15:0] schedAddr = '0;
  logic [7:0]  schedData = '0;

  anton_neopixel_apb_multi #(.CHANNELS(CH), .BANK_BITS(BB), .RESET_CYCLES(RC)) dut (
    .clk7mhz    (clk7mhz),
    .reset      (reset),
    .apbPselx   (apbPselx),
    .apbPenable (apbPenable),
    .apbPwrite  (apbPwrite),
    .apbPaddr   (apbPaddr),
    .apbPwData  (apbPwData),
    .apbPrData  (apbPrData),
    .apbPready  (apbPready),
    .apbPslverr (apbPslverr),
    .neoData    (neoData),
    .neoState   (neoState),
    .irq        (irq)
  );

  always #5 clk7mhz = ~clk7mhz;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // All bus tasks start and end on a falling edge.
  task automatic apbWrite(input logic [15:0] addr, input logic [7:0] data, output logic err);
    apbPselx = 1'b1; apbPenable = 1'b0; apbPwrite = 1'b1; apbPaddr = addr; apbPwData = data;
    @(negedge clk7mhz);
    apbPenable = 1'b1;
    #1 err = apbPslverr;
    @(negedge clk7mhz);
    apbPselx = 1'b0; apbPenable = 1'b0; apbPwrite = 1'b0;
  endtask

  task automatic apbRead(input logic [15:0] addr, output logic [7:0] data, output logic err);
    apbPselx = 1'b1; apbPenable = 1'b0; apbPwrite = 1'b0; apbPaddr = addr;
    @(negedge clk7mhz);
    apbPenable = 1'b1;
    #1 err = apbPslverr;
    data = apbPrData;
    @(negedge clk7mhz);
    apbPselx = 1'b0; apbPenable = 1'b0;
  endtask

  function automatic logic [15:0] bufAddr(input int ch, input int b);
    return 16'((ch << (BB + 2)) | (b << 2));
  endfunction

  task automatic writeBuf(input int ch, input int b, input logic [7:0] d);
    logic err;
    modelMem[ch][b] = d;
    apbWrite(bufAddr(ch, b), d, err);
    checkOutput("bufWriteErr", 32'(err), 0);
  endtask

  task automatic regWrite(input logic [15:0] addr, input logic [7:0] d);
    logic err;
    apbWrite(addr, d, err);
    checkOutput($sformatf("regWriteErr_%h", addr), 32'(err), 0);
  endtask

  task automatic readCheck(input string tag, input logic [15:0] addr, input logic [7:0] expData, input logic expErr);
    logic [7:0] d;
    logic       err;
    apbRead(addr, d, err);
    checkOutput({tag, "_err"}, 32'(err), 32'(expErr));
    checkOutput({tag, "_data"}, 32'(d), 32'(expData));
  endtask

  task automatic fillFrame(input int len);
    for (int b = 0; b <= len; b++)
      for (int c = 0; c < CH; c++)
        writeBuf(c, b, 8'($urandom));
  endtask

  // Expected strip levels k clocks into a frame: MSB first, 9 clocks per bit.
  function automatic logic [CH-1:0] expectedWave(input int k, input int len);
    logic [CH-1:0] w;
    int byteN, bitN, ph;
    w = '0;
    if (k < (len + 1) * 72) begin
      byteN = k / 72;
      bitN  = 7 - (k % 72) / 9;
      ph    = k % 9;
      for (int c = 0; c < CH; c++)
        w[c] = (ph < (modelMem[c][byteN][bitN] ? 6 : 3));
    end
    return w;
  endfunction

  task automatic applyStimulus(input int k);
    if (k == schedAt) begin
      apbPselx = 1'b1; apbPenable = 1'b0; apbPwrite = 1'b1;
      apbPaddr = schedAddr; apbPwData = schedData;
    end else if (k == schedAt + 1) begin
      apbPenable = 1'b1;
    end else if (k == schedAt + 2) begin
      apbPselx = 1'b0; apbPenable = 1'b0; apbPwrite = 1'b0;
    end
  endtask

  // Called on the falling edge right after the CTRL write that sets run.
  task automatic watchFrames(input int nFrames, input int len, input logic irqAtEnd);
    int period, total;
    logic expIrq, expBusy;
    period = (len + 1) * 72 + RC;
    total  = nFrames * period;
    checkOutput("busyBeforeStart", 32'({neoState, neoData}), 0);
    @(negedge clk7mhz);
    checkOutput("startLatency", 32'({neoState, neoData}), 32'({1'b1, {CH{1'b0}}}));
    for (int k = 0; k < total; k++) begin
      @(negedge clk7mhz);
      expIrq  = (k == total - 1) ? irqAtEnd : 1'b0;
      expBusy = (k != total - 1);
      checkOutput($sformatf("wave@%0d", k), 32'({irq, neoState, neoData}),
                  32'({expIrq, expBusy, expectedWave(k % period, len)}));
      applyStimulus(k);
    end
    schedAt = -1;
  endtask

  initial begin
    int len, ch, b;
    logic [7:0] d;
    logic err;

    repeat (3) @(posedge clk7mhz);
    @(negedge clk7mhz);
    reset = 1'b0;
    $display("[TB] reset released");
    checkOutput("rstNeoData", 32'(neoData), 0);
    checkOutput("rstNeoState", 32'(neoState), 0);
    checkOutput("rstIrq", 32'(irq), 0);
    checkOutput("rstPrData", 32'(apbPrData), 0);
    checkOutput("rstPslverr", 32'(apbPslverr), 0);
    checkOutput("rstPready", 32'(apbPready), 1);
    readCheck("rstCtrl", 16'h8000, 8'h00, 1'b0);
    readCheck("rstStatus", 16'h8004, 8'h00, 1'b0);
    readCheck("rstLength", 16'h8008, 8'h3F, 1'b0);
    readCheck("rstConfig", 16'h800C, 8'h04, 1'b0);

    $display("[TB] error decoding");
    writeBuf(0, 0, 8'h11);
    apbWrite(16'h0400, 8'h5A, err);
    checkOutput("wrCh4Err", 32'(err), 1);
    readCheck("ch0Unchanged", 16'h0000, modelMem[0][0], 1'b0);
    readCheck("rdCh4", 16'h0400, 8'h00, 1'b1);
    readCheck("rd8010", 16'h8010, 8'h00, 1'b1);
    writeBuf(3, 63, 8'h3C);
    readCheck("rd03FC", 16'h03FC, 8'h3C, 1'b0);
    regWrite(16'h800C, 8'h77);
    readCheck("configRO", 16'h800C, 8'h04, 1'b0);
    regWrite(16'h8008, 8'hFF);
    readCheck("lengthMask", 16'h8008, 8'h3F, 1'b0);

    $display("[TB] random buffer accesses");
    for (int i = 0; i < 8; i++) begin
      ch = $urandom_range(0, CH - 1);
      b  = $urandom_range(0, 63);
      writeBuf(ch, b, 8'($urandom));
      ch = $urandom_range(4, 127);
      apbWrite(16'((ch << (BB + 2)) | (b << 2)), 8'($urandom), err);
      checkOutput("rndErrWrite", 32'(err), 1);
      readCheck("rndAlias", bufAddr(ch % CH, b), modelMem[ch % CH][b], 1'b0);
    end

    $display("[TB] one-shot single byte");
    writeBuf(0, 0, 8'hA5);
    writeBuf(1, 0, 8'hFF);
    writeBuf(2, 0, 8'($urandom));
    writeBuf(3, 0, 8'($urandom));
    regWrite(16'h8008, 8'h00);
    regWrite(16'h8000, 8'h05);
    watchFrames(1, 0, 1'b1);
    readCheck("oneShotStatus", 16'h8004, 8'h02, 1'b0);
    checkOutput("oneShotIrq", 32'(irq), 1);
    readCheck("oneShotRunClr", 16'h8000, 8'h04, 1'b0);
    regWrite(16'h8004, 8'h02);
    checkOutput("w1cIrq", 32'(irq), 0);
    readCheck("w1cStatus", 16'h8004, 8'h00, 1'b0);

    $display("[TB] random one-shot");
    len = $urandom_range(1, 3);
    fillFrame(len);
    regWrite(16'h8008, 8'(len));
    regWrite(16'h8000, 8'h05);
    watchFrames(1, len, 1'b1);
    regWrite(16'h8004, 8'h02);
    readCheck("rndShotStatus", 16'h8004, 8'h00, 1'b0);

    $display("[TB] loop mode with mid-frame stop");
    fillFrame(2);
    regWrite(16'h8008, 8'h02);
    schedAt   = (3 * 72 + RC) + 98;
    schedAddr = 16'h8000;
    schedData = 8'h00;
    regWrite(16'h8000, 8'h03);
    watchFrames(2, 2, 1'b0);
    readCheck("loopStatus", 16'h8004, 8'h02, 1'b0);
    readCheck("loopCtrl", 16'h8000, 8'h00, 1'b0);
    regWrite(16'h8004, 8'h02);

    $display("[TB] done set against coincident W1C");
    fillFrame(0);
    regWrite(16'h8008, 8'h00);
    schedAt   = 72 + RC - 3;
    schedAddr = 16'h8004;
    schedData = 8'h02;
    regWrite(16'h8000, 8'h05);
    watchFrames(1, 0, 1'b1);
    readCheck("coincStatus", 16'h8004, 8'h02, 1'b0);
    regWrite(16'h8004, 8'h02);

    $display("[TB] reset during a frame");
    fillFrame(3);
    regWrite(16'h8008, 8'h03);
    regWrite(16'h8000, 8'h01);
    repeat (50) @(negedge clk7mhz);
    checkOutput("preResetBusy", 32'(neoState), 1);
    reset = 1'b1;
    @(negedge clk7mhz);
    checkOutput("midRstNeoData", 32'(neoData), 0);
    checkOutput("midRstNeoState", 32'(neoState), 0);
    checkOutput("midRstIrq", 32'(irq), 0);
    reset = 1'b0;
    readCheck("midRstCtrl", 16'h8000, 8'h00, 1'b0);
    readCheck("midRstLength", 16'h8008, 8'h3F, 1'b0);
    d = modelMem[2][1];
    readCheck("bufKeptOverReset", bufAddr(2, 1), d, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
